// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the per-core memory port front end.
package mem_pkg;
  localparam int ADDR_W = 16;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic              we;
  } data_in_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, LAT} mem_port_state_t;
endpackage

// File: rtl/mem_port_stat.sv
// mem_port_stat: saturating grant and stall counters, present only with MEM_PORT_STAT_EN.
module mem_port_stat (
  input  logic        clk,
  input  logic        rstn,
  input  logic        grant,
  input  logic        stall,
  output logic [31:0] stat_req,
  output logic [31:0] stat_stall
);
  logic [31:0] req_q, req_d, stall_q, stall_d;
  always_comb begin
    req_d   = (grant && req_q != '1) ? req_q + 32'd1 : req_q;
    stall_d = (stall && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_q   <= '0;
      stall_q <= '0;
    end else begin
      req_q   <= req_d;
      stall_q <= stall_d;
    end
  end
  assign stat_req   = req_q;
  assign stat_stall = stall_q;
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: one core's dual-lane load/store front end to a shared-memory arbiter slot.
// Defining MEM_PORT_STAT_EN adds the stat_req/stat_stall counter outputs.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_valid,
  input  data_in_t    u_op,
  input  data_in_t    l_op,
  output logic        op_ready,
  output logic        interlock,
  output logic [31:0] u_rdata,
  output logic [31:0] l_rdata,
  output logic        rdata_valid,
  output logic        mem_req_now,
  output data_in_t    u_data_in,
  output data_in_t    l_data_in,
  input  logic        mem_wait,
  input  logic [31:0] u_data_out,
`ifdef MEM_PORT_STAT_EN
  input  logic [31:0] l_data_out,
  output logic [31:0] stat_req,
  output logic [31:0] stat_stall
`else
  input  logic [31:0] l_data_out
`endif
);
  localparam int CNT_W = 3;
  mem_port_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_in_t u_op_q, u_op_d, l_op_q, l_op_d;
  logic is_read_q, is_read_d, rdata_valid_q, rdata_valid_d;
  logic [31:0] u_rdata_q, u_rdata_d, l_rdata_q, l_rdata_d;
  logic accept, active, grant, cap;
  always_comb begin
    accept        = state_q == IDLE && op_valid;
    active        = state_q == REQ || state_q == WAIT;
    grant         = active && !mem_wait;
    cap           = state_q == LAT && cnt_q == '0;
    state_d       = accept ? REQ :
                    grant ? (is_read_q ? LAT : IDLE) :
                    active ? WAIT :
                    cap ? IDLE : state_q;
    cnt_d         = grant ? CNT_W'(RD_LATENCY - 1) :
                    (state_q == LAT && !cap) ? cnt_q - 1'b1 : cnt_q;
    u_op_d        = accept ? u_op : u_op_q;
    l_op_d        = accept ? l_op : l_op_q;
    is_read_d     = accept ? ~(u_op.we & l_op.we) : is_read_q;
    u_rdata_d     = cap ? u_data_out : u_rdata_q;
    l_rdata_d     = cap ? l_data_out : l_rdata_q;
    rdata_valid_d = cap;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      u_op_q        <= '0;
      l_op_q        <= '0;
      is_read_q     <= 1'b0;
      u_rdata_q     <= '0;
      l_rdata_q     <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      u_op_q        <= u_op_d;
      l_op_q        <= l_op_d;
      is_read_q     <= is_read_d;
      u_rdata_q     <= u_rdata_d;
      l_rdata_q     <= l_rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end
  assign op_ready    = state_q == IDLE;
  assign interlock   = ~op_ready;
  assign mem_req_now = state_q == REQ;
  assign rdata_valid = rdata_valid_q;
  assign u_rdata     = u_rdata_q;
  assign l_rdata     = l_rdata_q;
  // Write enables only reach the arbiter while the request is outstanding.
  assign u_data_in   = '{addr: u_op_q.addr, din: u_op_q.din, we: u_op_q.we & active};
  assign l_data_in   = '{addr: l_op_q.addr, din: l_op_q.din, we: l_op_q.we & active};
`ifdef MEM_PORT_STAT_EN
  mem_port_stat u_stat (
    .clk       (clk),
    .rstn      (rstn),
    .grant     (grant),
    .stall     (state_q == WAIT),
    .stat_req  (stat_req),
    .stat_stall(stat_stall)
  );
`endif
endmodule
